// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the per-port FIFO used around the 4-port
// routing arbiter.
//   DATA_W_DEF        default word width (10 bits)
//   DEST_MSB/DEST_LSB destination field position within a word ([9:8])
//   word_t            one stored word (destination + 8-bit payload)
//   cnt_w(depth)      width of an occupancy counter able to hold 0..depth
package fifo_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int DEST_MSB   = 9;
    localparam int DEST_LSB   = 8;

    typedef logic [DATA_W_DEF-1:0] word_t;

    // One extra bit over the address width so that "completely full" (count ==
    // depth) is representable alongside "empty" (count == 0).
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// fifo_flags_if: producer/consumer side of one FIFO instance.
//   master modport : the arbiter / producer side (drives push, data_in, pop)
//   slave modport  : the FIFO itself (drives data_out and all flags)
// Handshake: a word is written on a rising edge where push is high and the
// FIFO is not full (or is full but a pop is accepted on the same edge); a
// word is read on a rising edge where pop is high and the FIFO is not empty,
// and appears on data_out after that edge. The flags are the "ready" side:
// the producer is expected to watch almost_full / full, the consumer empty.
interface fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8
) ();

    localparam int CW = cnt_w(DEPTH);

    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;

    modport master (
        output push, data_in, pop,
        input  data_out, empty, full, almost_full, almost_empty, count
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, empty, full, almost_full, almost_empty, count
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W storage with one write port and one registered
// read port.
//   clk, rst           clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data   write port, written on the rising edge
//   rd_en/rd_addr      read request; rd_data updates on the rising edge
//   rd_data            registered read data, holds when rd_en is low
// The array itself is never reset. A read and write to the same address on the
// same edge returns the old contents, which is what a full FIFO doing a
// simultaneous push/pop needs (the oldest word leaves, the new one replaces it).
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with occupancy flags, one per arbiter port.
//   clk            rising-edge clock
//   rst            asynchronous active-low reset, released synchronously
//   bus (slave)    push/data_in/pop in; data_out/empty/full/almost_full/
//                  almost_empty/count out (see fifo_flags_if)
//   err_overflow   (FIFO_ERR_EN only) sticky: a push was dropped while full
//   err_underflow  (FIFO_ERR_EN only) sticky: a pop arrived while empty
// Build option: define FIFO_ERR_EN to add the two sticky error outputs.
// Occupancy is kept in its own counter rather than derived from the pointers,
// and every flag is a decode of that registered counter, so nothing on the
// push/pop inputs reaches a flag combinationally.
// ALM_FULL_LVL should leave at least 3 free entries when the producer is the
// arbiter's pop-to-push pipeline (use DEPTH-3 there); the default of 6 of 8
// only suits producers that stop within 2 cycles.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int DEPTH         = 8,
    parameter int ALM_FULL_LVL  = 6,
    parameter int ALM_EMPTY_LVL = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_flags_if.slave    bus
`ifdef FIFO_ERR_EN
    ,
    output logic           err_overflow,
    output logic           err_underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(ALM_FULL_LVL);
    localparam logic [CW-1:0] CNT_AEMPT = CW'(ALM_EMPTY_LVL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          is_empty;
    logic          is_full;
    logic          pop_acc;
    logic          push_acc;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // A pop on an empty FIFO is never accepted, even with a same-cycle push:
    // there is no fall-through path from data_in to data_out.
    assign pop_acc  = bus.pop & ~is_empty;
    // When full, a push still fits if the same edge frees a slot.
    assign push_acc = bus.push & (~is_full | pop_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr),
        .rd_data (bus.data_out)
    );

    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (count_q >= CNT_AFULL);
    assign bus.almost_empty = (count_q <= CNT_AEMPT);

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (bus.push & ~push_acc) begin
                err_overflow <= 1'b1;
            end
            if (bus.pop & is_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed test-plan sequence followed by randomized push/pop
// traffic, with a queue-based reference model checked every cycle.
module tb_fifo_flags;
    import fifo_pkg::*;

    localparam int DATA_W = DATA_W_DEF;
    localparam int DEPTH  = 8;
    localparam int AFL    = 6;
    localparam int AEL    = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;

    fifo_flags_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef FIFO_ERR_EN
    logic err_overflow;
    logic err_underflow;
`endif

    fifo_flags #(
        .DATA_W        (DATA_W),
        .DEPTH         (DEPTH),
        .ALM_FULL_LVL  (AFL),
        .ALM_EMPTY_LVL (AEL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave)
`ifdef FIFO_ERR_EN
        ,
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    word_t m_q[$];
    word_t m_dout = '0;
    bit    m_ovf  = 1'b0;
    bit    m_unf  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            bit pop_ok;
            bit push_ok;
            pop_ok  = bus.pop && (m_q.size() > 0);
            push_ok = bus.push && ((m_q.size() < DEPTH) || pop_ok);
            if (bus.push && !push_ok) m_ovf = 1'b1;
            if (bus.pop && m_q.size() == 0) m_unf = 1'b1;
            if (pop_ok) m_dout = m_q.pop_front();
            if (push_ok) m_q.push_back(bus.data_in);
        end
    end

    always @(negedge rst) begin
        m_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        int n;
        n = m_q.size();
        check("cyc_data_out", int'(bus.data_out), int'(m_dout));
        check("cyc_count", int'(bus.count), n);
        check("cyc_empty", int'(bus.empty), int'(n == 0));
        check("cyc_full", int'(bus.full), int'(n == DEPTH));
        check("cyc_almost_full", int'(bus.almost_full), int'(n >= AFL));
        check("cyc_almost_empty", int'(bus.almost_empty), int'(n <= AEL));
`ifdef FIFO_ERR_EN
        check("cyc_err_overflow", int'(err_overflow), int'(m_ovf));
        check("cyc_err_underflow", int'(err_underflow), int'(m_unf));
`endif
    end

    // ---------------- driver ----------------
    // Apply one cycle of inputs (called just after a falling edge) and return
    // after the next falling edge, when the resulting state is visible.
    task automatic cycle(input bit p, input int d, input bit q);
        bus.push    = p;
        bus.data_in = DATA_W'(d);
        bus.pop     = q;
        @(negedge clk);
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.data_in = '0;
        bus.pop     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // reset state
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_almost_empty", int'(bus.almost_empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_almost_full", int'(bus.almost_full), 0);
        check("rst_data_out", int'(bus.data_out), 0);

        // fill 0x101..0x108
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 'h100 + i, 1'b0);
            check("fill_count", int'(bus.count), i);
            check("fill_empty", int'(bus.empty), 0);
            check("fill_almost_full", int'(bus.almost_full), int'(i >= 6));
        end
        check("fill_full", int'(bus.full), 1);
        check("model_size_full", m_q.size(), 8);

        // overflow: dropped
        cycle(1'b1, 'h3FF, 1'b0);
        check("ovf_count", int'(bus.count), 8);
`ifdef FIFO_ERR_EN
        check("ovf_err", int'(err_overflow), 1);
        cycle(1'b0, 0, 1'b0);
        check("ovf_err_sticky", int'(err_overflow), 1);
`endif

        // drain in order
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 0, 1'b1);
            check("drain_data", int'(bus.data_out), 'h100 + i);
            check("drain_almost_empty", int'(bus.almost_empty), int'((8 - i) <= 1));
        end
        check("drain_empty", int'(bus.empty), 1);

        // underflow: data_out holds
        cycle(1'b0, 0, 1'b1);
        check("unf_data", int'(bus.data_out), 'h108);
        check("unf_count", int'(bus.count), 0);
`ifdef FIFO_ERR_EN
        check("unf_err", int'(err_underflow), 1);
`endif

        // empty + push + pop: pop ignored
        cycle(1'b1, 'h055, 1'b1);
        check("emp_pp_count", int'(bus.count), 1);
        check("emp_pp_data", int'(bus.data_out), 'h108);
        cycle(1'b0, 0, 1'b1);
        check("emp_pp_read", int'(bus.data_out), 'h055);

        // full + push + pop: both accepted, pointer wraps
        for (int i = 1; i <= 8; i++) cycle(1'b1, 'h100 + i, 1'b0);
        cycle(1'b1, 'h2AA, 1'b1);
        check("full_pp_count", int'(bus.count), 8);
        check("full_pp_data", int'(bus.data_out), 'h101);
        for (int i = 2; i <= 9; i++) begin
            cycle(1'b0, 0, 1'b1);
            check("full_pp_drain", int'(bus.data_out), (i == 9) ? 'h2AA : ('h100 + i));
        end

        // async reset mid-stream at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 'h010 + i, 1'b0);
        check("pre_rst_count", int'(bus.count), 5);
        bus.push = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_count", int'(bus.count), 0);
        check("arst_empty", int'(bus.empty), 1);
        check("arst_data", int'(bus.data_out), 0);
        check("model_size_arst", m_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 'h077, 1'b0);
        cycle(1'b0, 0, 1'b1);
        check("post_rst_read", int'(bus.data_out), 'h077);
        check("post_rst_empty", int'(bus.empty), 1);
`ifdef FIFO_ERR_EN
        check("post_rst_err_ovf", int'(err_overflow), 0);
        check("post_rst_err_unf", int'(err_underflow), 0);
`endif

        // randomized traffic with shifting push/pop bias
        begin
            int bias;
            bias = 50;
            for (int c = 0; c < 800; c++) begin
                if (c % 40 == 0) bias = $urandom_range(10, 90);
                if (c == 400) begin
                    #2 rst = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                end
                cycle(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                      int'($urandom_range(0, 1023)),
                      ($urandom_range(0, 99) >= bias) ? 1'b1 : 1'b0);
            end
        end

        cycle(1'b0, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Synchronous FIFO with occupancy flags, instantiated once per port.
- Sits directly upstream of the 4-port routing arbiter as each input queue, and downstream of it as each output queue.
- Stores 10-bit words (destination in [9:8], payload in [7:0]).
- Drives empty, almost_full and registered read data with the one-cycle pop-to-data timing the arbiter consumes.

Parameters:
- DATA_W, 10, word width in bits.
- DEPTH, 8, number of entries; must be a power of two, minimum 4.
- ALM_FULL_LVL, 6, almost_full asserts when count >= this value (1..DEPTH).
- ALM_EMPTY_LVL, 1, almost_empty asserts when count <= this value (0..DEPTH-1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- push  in  1  write request.
- data_in  in  DATA_W  write data, sampled with push.
- pop  in  1  read request.
- data_out  out  DATA_W  registered read data, valid the cycle after an accepted pop.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= ALM_FULL_LVL.
- almost_empty  out  1  count <= ALM_EMPTY_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst low), asynchronous, all outputs:
  - wr_ptr = 0, rd_ptr = 0, count = 0, data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words.
- Pointers:
  - $clog2(DEPTH) bits wide; wrap naturally from DEPTH-1 to 0.
  - count is tracked separately; it is never derived from pointer difference.
- Push acceptance:
  - Accepted when push & (!full | pop_acc), where pop_acc is the pop acceptance defined below.
  - Accepted push: mem[wr_ptr] <= data_in, wr_ptr increments.
- Pop acceptance:
  - Accepted when pop & !empty.
  - Accepted pop: data_out <= mem[rd_ptr] on that edge, rd_ptr increments. Latency is one cycle from pop to data_out.
  - data_out holds its last value when no pop is accepted.
- Count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous accepted push and pop, or when neither is accepted.
- Boundary conditions:
  - Full with push & pop: both accepted, count stays DEPTH.
  - Empty with push & pop: pop ignored (no fall-through), push accepted, count becomes 1, data_out unchanged.
  - Push while full without pop: word dropped, no state change.
  - Pop while empty: ignored, data_out unchanged.
- Flags:
  - Combinational decodes of the registered count only.
  - Never depend combinationally on push or pop, so no path exists from the arbiter's pop to empty.
- Backpressure margin:
  - ALM_FULL_LVL must leave at least 3 free entries for the arbiter's pop-to-push pipeline.
  - Default 6 of 8 leaves 2 free, so the default is only valid when the upstream producer throttles within 2 cycles.
  - Instantiations behind the arbiter set ALM_FULL_LVL = DEPTH-3.

Optional Feature:
- Macro: FIFO_ERR_EN.
- Defined:
  - Adds ports err_overflow (out, 1) and err_underflow (out, 1), both sticky and cleared only by rst.
  - err_overflow sets on a dropped push; err_underflow sets on a pop while empty.
  - Both set on the edge following the offending request.
- Undefined:
  - Ports absent.
  - Dropped and ignored requests behave identically, with no indication.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W_DEF = 10 and DEST_MSB/DEST_LSB = 9/8.
  - Typedef word_t (DATA_W-bit vector) and a function cnt_w(depth) returning $clog2(depth)+1.
- One natural sub-module: fifo_mem_2p.
  - DEPTH x DATA_W register array with one write port and one registered read port.
  - Has write enable, write address, read enable and read address.
  - fifo_flags keeps pointers, count and flags.

Test Plan:
- Reset then fill: push 0x101..0x108, one per cycle -> count 1..8; almost_full rises when count reaches 6; full = 1 at 8; empty falls after the first edge.
- Drain order: pop 8 times after fill -> data_out = 0x101..0x108, each one cycle after its pop; empty = 1 after the 8th; almost_empty = 1 at count <= 1.
- Overflow: 9th push of 0x3FF while full -> dropped, count stays 8; with FIFO_ERR_EN, err_overflow = 1 next cycle and stays 1.
- Simultaneous at limits:
  - Full + push 0x2AA + pop -> count 8, wr_ptr wraps, 0x2AA read out 8 pops later.
  - Empty + push 0x055 + pop -> count 1, data_out unchanged.
- Underflow: pop while empty with data_out = 0x108 -> data_out stays 0x108, count 0; with FIFO_ERR_EN, err_underflow = 1.
- Async reset mid-stream: rst low between edges at count 5 -> count 0, empty 1, data_out 0 immediately; the next push 0x077 then pop returns 0x077.
